typing_game_ctrl: RTL and testbench

//  Parametrised N-round letter-reaction game controller. Sits between kbdWrapper (key_code) and
//  the display/LED logic. Each round it draws a pseudo-random goal letter, times the player's

---
 rtl/typing_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_typing_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_game_ctrl.sv
// typing_game_ctrl: N-round letter-reaction game controller.
// Draws a pseudo-random goal letter per round, times the player's response
// in ms, scores hit/miss/timeout and reports win/loss after ROUNDS rounds.
// Optional feature macro: TYPING_GAME_BEST_TIME_EN (tracks fastest hit in best_ms).
module typing_game_ctrl #(
   parameter int CODE_W       = 5,
   parameter int RELEASE_CODE = 21,
   parameter int ALPHA_N      = 20,
   parameter int ROUNDS       = 8,
   parameter int WIN_MIN      = 6,
   parameter int TICK_DIV     = 100000,
   parameter int TIME_W       = 14,
   parameter int TIMEOUT_MS   = 2000,
   localparam int RW          = $clog2(ROUNDS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] key_code,
   output logic [CODE_W-1:0] goal,
   output logic              goal_vld,
   output logic [1:0]        state,
   output logic [RW-1:0]     round_idx,
   output logic [RW-1:0]     score,
   output logic [TIME_W-1:0] elapsed_ms,
   output logic [TIME_W-1:0] last_ms,
   output logic              win,
   output logic              loss,
   output logic [TIME_W-1:0] best_ms
);

   localparam int                PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CODE_W-1:0] REL      = CODE_W'(RELEASE_CODE);
   localparam logic [CODE_W:0]   ALPHA    = (CODE_W + 1)'(ALPHA_N);
   localparam logic [RW-1:0]     LAST_RND = RW'(ROUNDS - 1);
   localparam logic [RW-1:0]     WIN_THR  = RW'(WIN_MIN);
   localparam logic [TIME_W-1:0] TMO      = TIME_W'(TIMEOUT_MS);
   localparam logic [TIME_W-1:0] T_MAX    = '1;
   localparam logic [PW-1:0]     PRE_TOP  = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_REL = 2'd1,
      S_PLAY     = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t            st;
   logic              tgt_done;   // where WAIT_REL goes on release: 1 = DONE, 0 = PLAY
   logic [CODE_W-1:0] prev_key;
   logic [15:0]       lfsr;
   logic [PW-1:0]     presc;

   logic [CODE_W-1:0] draw_raw;
   logic [CODE_W-1:0] draw;
   logic              press;
   logic              hit;
   logic              tick;
   logic              timeout;
   logic              last_rnd;
   logic [TIME_W-1:0] elapsed_inc;

   assign state = st;

   // Edge-detected key press, letter draw folded into 0..ALPHA_N-1, and tick/timeout decode
   always_comb begin
      draw_raw    = lfsr[CODE_W-1:0];
      draw        = ({1'b0, draw_raw} >= ALPHA) ? (draw_raw - ALPHA[CODE_W-1:0]) : draw_raw;
      press       = (key_code != prev_key) && (key_code != REL);
      hit         = press && (key_code == goal);
      tick        = (presc == PRE_TOP);
      timeout     = (elapsed_ms == TMO);
      last_rnd    = (round_idx == LAST_RND);
      elapsed_inc = (elapsed_ms == T_MAX) ? elapsed_ms : (elapsed_ms + TIME_W'(1));
   end

   // Previous-key register and free-running Galois LFSR (taps 0xB400, never reaches zero)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_key <= REL;
         lfsr     <= 16'hACE1;
      end else begin
         prev_key <= key_code;
         lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   // Game FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= S_IDLE;
         tgt_done   <= 1'b0;
         goal       <= '0;
         goal_vld   <= 1'b0;
         round_idx  <= '0;
         score      <= '0;
         elapsed_ms <= '0;
         last_ms    <= '0;
         presc      <= '0;
         win        <= 1'b0;
         loss       <= 1'b0;
      end else begin
         case (st)
            S_IDLE: begin
               if (press) begin
                  st        <= S_WAIT_REL;
                  tgt_done  <= 1'b0;
                  score     <= '0;
                  round_idx <= '0;
               end
            end
            S_WAIT_REL: begin
               if (key_code == REL) begin
                  if (tgt_done) begin
                     st       <= S_DONE;
                     goal_vld <= 1'b0;
                     win      <= (score >= WIN_THR);
                     loss     <= !(score >= WIN_THR);
                  end else begin
                     st         <= S_PLAY;
                     goal       <= draw;
                     goal_vld   <= 1'b1;
                     elapsed_ms <= '0;
                     presc      <= '0;
                  end
               end
            end
            S_PLAY: begin
               // A press wins over a simultaneous timeout; elapsed_ms freezes when the round ends
               if (press) begin
                  if (hit) begin
                     score   <= score + RW'(1);
                     last_ms <= elapsed_ms;
                  end
                  st       <= S_WAIT_REL;
                  goal_vld <= 1'b0;
                  tgt_done <= last_rnd;
                  if (!last_rnd) begin
                     round_idx <= round_idx + RW'(1);
                  end
               end else if (timeout) begin
                  if (last_rnd) begin
                     st       <= S_DONE;
                     goal_vld <= 1'b0;
                     win      <= (score >= WIN_THR);
                     loss     <= !(score >= WIN_THR);
                  end else begin
                     round_idx  <= round_idx + RW'(1);
                     goal       <= draw;
                     elapsed_ms <= '0;
                     presc      <= '0;
                  end
               end else if (tick) begin
                  presc      <= '0;
                  elapsed_ms <= elapsed_inc;
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            S_DONE: begin
               if (press) begin
                  st        <= S_WAIT_REL;
                  tgt_done  <= 1'b0;
                  score     <= '0;
                  round_idx <= '0;
                  win       <= 1'b0;
                  loss      <= 1'b0;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

`ifdef TYPING_GAME_BEST_TIME_EN
   // Fastest hit since reset; a new game keeps it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         best_ms <= '1;
      end else if ((st == S_PLAY) && hit && (elapsed_ms < best_ms)) begin
         best_ms <= elapsed_ms;
      end
   end
`else
   assign best_ms = '1;
`endif

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Testbench for typing_game_ctrl: directed game scenarios followed by random
// key traffic, every cycle compared against a behavioural game model.
module tb_typing_game_ctrl;

   localparam int CODE_W  = 5;
   localparam int REL     = 21;
   localparam int ALPHA_N = 20;
   localparam int ROUNDS  = 3;
   localparam int WIN_MIN = 2;
   localparam int TICK    = 4;
   localparam int TIME_W  = 14;
   localparam int TMO     = 10;
   localparam int RW      = $clog2(ROUNDS + 1);
   localparam int T_MAX   = (1 << TIME_W) - 1;

   logic              clk;
   logic              rst_n;
   logic [CODE_W-1:0] key_code;
   logic [CODE_W-1:0] goal;
   logic              goal_vld;
   logic [1:0]        state;
   logic [RW-1:0]     round_idx;
   logic [RW-1:0]     score;
   logic [TIME_W-1:0] elapsed_ms;
   logic [TIME_W-1:0] last_ms;
   logic              win;
   logic              loss;
   logic [TIME_W-1:0] best_ms;

   typing_game_ctrl #(
      .CODE_W(CODE_W), .RELEASE_CODE(REL), .ALPHA_N(ALPHA_N), .ROUNDS(ROUNDS),
      .WIN_MIN(WIN_MIN), .TICK_DIV(TICK), .TIME_W(TIME_W), .TIMEOUT_MS(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_code(key_code), .goal(goal), .goal_vld(goal_vld),
      .state(state), .round_idx(round_idx), .score(score), .elapsed_ms(elapsed_ms),
      .last_ms(last_ms), .win(win), .loss(loss), .best_ms(best_ms)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Game model: phase 0 idle, 1 waiting for release, 2 playing, 3 game over
   int m_phase, m_goal, m_round, m_score, m_cyc, m_last, m_best, m_lfsr, m_prev;
   bit m_to_done, m_vld, m_win, m_loss;
   int cur_key;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int letter_of(input int l);
      int r;
      r = l % 32;
      return (r >= ALPHA_N) ? r - ALPHA_N : r;
   endfunction

   function automatic int ms_of(input int cyc);
      int ms;
      ms = cyc / TICK;
      return (ms > T_MAX) ? T_MAX : ms;
   endfunction

   task automatic end_game();
      m_phase = 3;
      m_vld   = 0;
      m_win   = (m_score >= WIN_MIN);
      m_loss  = !m_win;
   endtask

   task automatic model_step(input int k, input bit rn);
      bit press;
      int ms;
      if (!rn) begin
         m_phase = 0; m_to_done = 0; m_goal = 0; m_round = 0; m_score = 0;
         m_cyc = 0; m_last = 0; m_vld = 0; m_win = 0; m_loss = 0;
         m_best = T_MAX; m_lfsr = 'hACE1; m_prev = REL;
         return;
      end
      press = (k != m_prev) && (k != REL);
      ms    = ms_of(m_cyc);
      case (m_phase)
         0: if (press) begin
            m_phase = 1; m_to_done = 0; m_score = 0; m_round = 0;
         end
         1: if (k == REL) begin
            if (m_to_done) end_game();
            else begin
               m_phase = 2; m_goal = letter_of(m_lfsr); m_cyc = 0; m_vld = 1;
            end
         end
         2: begin
            if (press) begin
               if (k == m_goal) begin
                  m_score++;
                  m_last = ms;
`ifdef TYPING_GAME_BEST_TIME_EN
                  if (ms < m_best) m_best = ms;
`endif
               end
               m_phase = 1; m_vld = 0;
               if (m_round == ROUNDS - 1) m_to_done = 1;
               else begin
                  m_to_done = 0; m_round++;
               end
            end else if (ms == TMO) begin
               if (m_round == ROUNDS - 1) end_game();
               else begin
                  m_round++; m_goal = letter_of(m_lfsr); m_cyc = 0;
               end
            end else begin
               m_cyc++;
            end
         end
         default: if (press) begin
            m_phase = 1; m_to_done = 0; m_score = 0; m_round = 0; m_win = 0; m_loss = 0;
         end
      endcase
      m_prev = k;
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
   endtask

   task automatic compare_all();
      check_eq("state", 32'(state), 32'(m_phase));
      check_eq("goal", 32'(goal), 32'(m_goal));
      check_eq("goal_vld", 32'(goal_vld), 32'(m_vld));
      check_eq("round_idx", 32'(round_idx), 32'(m_round));
      check_eq("score", 32'(score), 32'(m_score));
      check_eq("elapsed_ms", 32'(elapsed_ms), 32'(ms_of(m_cyc)));
      check_eq("last_ms", 32'(last_ms), 32'(m_last));
      check_eq("win", 32'(win), 32'(m_win));
      check_eq("loss", 32'(loss), 32'(m_loss));
      check_eq("best_ms", 32'(best_ms), 32'(m_best));
   endtask

   task automatic step(input int k, input bit rn);
      rst_n    = rn;
      key_code = k[CODE_W-1:0];
      cur_key  = k;
      @(posedge clk);
      model_step(k, rn);
      #1;
      compare_all();
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(REL, 1'b1);
   endtask

   initial begin
      int r;
      int k;
      int wrong;
      rst_n    = 1'b0;
      key_code = CODE_W'(REL);
      cur_key  = REL;

      // Reset state
      step(REL, 1'b0);
      step(REL, 1'b0);
      check_eq("rst_state", 32'(state), 0);
      check_eq("rst_best", 32'(best_ms), 32'(T_MAX));
      check_eq("rst_goal_vld", 32'(goal_vld), 0);

      // Start: key 3 then release
      step(3, 1'b1);
      check_eq("s1_wait", 32'(state), 1);
      step(REL, 1'b1);
      check_eq("s1_play", 32'(state), 2);
      check_eq("s1_goal_range", 32'(goal < CODE_W'(ALPHA_N)), 1);
      check_eq("s1_elapsed", 32'(elapsed_ms), 0);
      check_eq("s1_round", 32'(round_idx), 0);

      // Hit after 6 ms
      hold(6 * TICK);
      step(m_goal, 1'b1);
      step(REL, 1'b1);
      check_eq("s2_score", 32'(score), 1);
      check_eq("s2_last", 32'(last_ms), 6);
      check_eq("s2_round", 32'(round_idx), 1);
      check_eq("s2_play", 32'(state), 2);

      // Press on the very cycle the timeout would fire
      hold(TMO * TICK);
      check_eq("s5_elapsed", 32'(elapsed_ms), TMO);
      step(m_goal, 1'b1);
      check_eq("s5_wait", 32'(state), 1);
      check_eq("s5_round", 32'(round_idx), 2);
      check_eq("s5_score", 32'(score), 2);
      step(REL, 1'b1);
      step(m_goal, 1'b1);
      step(REL, 1'b1);
      check_eq("g1_done", 32'(state), 3);
      check_eq("g1_win", 32'(win), 1);

      // New game, wrong letter, then two timeouts
      step(7, 1'b1);
      step(REL, 1'b1);
      check_eq("g2_score", 32'(score), 0);
      wrong = (m_goal + 1) % ALPHA_N;
      step(wrong, 1'b1);
      step(REL, 1'b1);
      hold(TMO * TICK + 1);
      check_eq("s3_round2", 32'(round_idx), 2);
      check_eq("s3_play", 32'(state), 2);
      hold(TMO * TICK + 1);
      check_eq("s3_done", 32'(state), 3);
      check_eq("s3_score", 32'(score), 0);
      check_eq("s3_loss", 32'(loss), 1);
      check_eq("s3_win", 32'(win), 0);

      // Reset in the middle of a round
      step(5, 1'b1);
      step(REL, 1'b1);
      hold(8);
      step(REL, 1'b0);
      check_eq("s6_state", 32'(state), 0);
      check_eq("s6_goal", 32'(goal), 0);
      check_eq("s6_vld", 32'(goal_vld), 0);
      check_eq("s6_elapsed", 32'(elapsed_ms), 0);
      check_eq("s6_last", 32'(last_ms), 0);
      check_eq("s6_score", 32'(score), 0);
      check_eq("s6_best", 32'(best_ms), 32'(T_MAX));

      // Three straight hits then a fresh game
      step(5, 1'b1);
      step(REL, 1'b1);
      for (int i = 0; i < ROUNDS; i++) begin
         hold(3 + i);
         step(m_goal, 1'b1);
         step(REL, 1'b1);
      end
      check_eq("s4_done", 32'(state), 3);
      check_eq("s4_score", 32'(score), 3);
      check_eq("s4_win", 32'(win), 1);
      step(9, 1'b1);
      step(REL, 1'b1);
      check_eq("s4_new_score", 32'(score), 0);
      check_eq("s4_new_win", 32'(win), 0);
      check_eq("s4_new_play", 32'(state), 2);

      // Random key traffic
      for (int c = 0; c < 5000; c++) begin
         r = int'($urandom_range(99));
         if (r < 50)      k = cur_key;
         else if (r < 72) k = REL;
         else if (r < 86) k = m_goal;
         else             k = int'($urandom_range(31));
         step(k, ($urandom_range(399) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
